// File: rtl/regfile_arb_pkg.sv
// Shared types and constants for the register-file read-port arbiter.
package regfile_arb_pkg;

   localparam int unsigned REG_ADDR_W = 5;
   localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

   typedef enum logic {
      IDLE = 1'b0,
      RESP = 1'b1
   } state_t;

endpackage : regfile_arb_pkg

// File: rtl/regfile_read_arbiter_rr_arbiter.sv
// Round-robin arbiter: first asserted request at or after the pointer wins, wrapping to 0.
module rr_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ID_W    = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   input  logic               en,
   output logic [NUM_REQ-1:0] grant_c,
   output logic [ID_W-1:0]    winner_c,
   output logic               any_c
);

   int unsigned idx;

   // Scan offsets from the pointer; requester i is only indexed by a constant to keep selects static.
   always_comb begin
      grant_c  = '0;
      winner_c = '0;
      any_c    = 1'b0;
      idx      = 0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         idx = (32'(ptr) + k) % NUM_REQ;
         for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (en && !any_c && (idx == i) && req[i]) begin
               any_c      = 1'b1;
               grant_c[i] = 1'b1;
               winner_c   = ID_W'(i);
            end
         end
      end
   end

endmodule : rr_arbiter

// File: rtl/regfile_read_arbiter.sv
// Shares the single register-file read port among NUM_REQ requesters with a registered response.
// Optional same-cycle write forwarding when REGFILE_ARB_BYPASS_EN is defined.
module regfile_read_arbiter
   import regfile_arb_pkg::*;
#(
   parameter int unsigned N       = 32,
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ID_W    = 2
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [NUM_REQ-1:0]               in_Req_Valid,
   input  logic [REG_ADDR_W*NUM_REQ-1:0]    in_Req_Addr,
   output logic [NUM_REQ-1:0]               o_Req_Ready,
   output logic [REG_ADDR_W-1:0]            o_MUX_Selector_5,
   input  logic [N-1:0]                     in_MUX_Data,
   input  logic                             in_Wr_En,
   input  logic [REG_ADDR_W-1:0]            in_Wr_Addr,
   input  logic [N-1:0]                     in_Wr_Data,
   output logic                             o_Rsp_Valid,
   output logic [ID_W-1:0]                  o_Rsp_Id,
   output logic [N-1:0]                     o_Rsp_Data,
   input  logic                             in_Rsp_Ready
);

   state_t                  state_q, state_d;
   logic                    slot_free_c;
   logic                    grant_any_c;
   logic [NUM_REQ-1:0]      grant_c;
   logic [ID_W-1:0]         winner_c;
   logic [ID_W-1:0]         ptr_q;
   logic [ID_W-1:0]         ptr_next_c;
   logic [REG_ADDR_W-1:0]   win_addr_c;
   logic [REG_ADDR_W-1:0]   last_sel_q;
   logic                    bypass_hit_c;
   logic [N-1:0]            cap_data_c;

   // Output slot is free when empty or when the held response leaves this cycle; no grants in reset.
   assign slot_free_c = reset & ((state_q == IDLE) | in_Rsp_Ready);

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_rr (
      .req      (in_Req_Valid),
      .ptr      (ptr_q),
      .en       (slot_free_c),
      .grant_c  (grant_c),
      .winner_c (winner_c),
      .any_c    (grant_any_c)
   );

   always_comb begin
      win_addr_c = REG_ZERO;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (ID_W'(i) == winner_c) begin
            win_addr_c = in_Req_Addr[i*REG_ADDR_W +: REG_ADDR_W];
         end
      end
   end

`ifdef REGFILE_ARB_BYPASS_EN
   assign bypass_hit_c = in_Wr_En & (in_Wr_Addr == win_addr_c);
`else
   logic unused_wr;
   assign bypass_hit_c = 1'b0;
   assign unused_wr    = &{1'b0, in_Wr_En, in_Wr_Addr, in_Wr_Data};
`endif

   // r0 reads as zero regardless of what the mux or a snooped write present.
   assign cap_data_c = (win_addr_c == REG_ZERO) ? '0 :
                       bypass_hit_c             ? in_Wr_Data : in_MUX_Data;

   assign ptr_next_c = (32'(winner_c) == NUM_REQ - 1) ? '0 : winner_c + ID_W'(1);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d          = state_q;
      o_Req_Ready      = grant_c;
      o_MUX_Selector_5 = last_sel_q;
      if (grant_any_c) begin
         state_d          = RESP;
         o_MUX_Selector_5 = win_addr_c;
      end else if ((state_q == RESP) && in_Rsp_Ready) begin
         state_d = IDLE;
      end
   end

   // Response registers, RR pointer and last selector value.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         o_Rsp_Valid <= 1'b0;
         o_Rsp_Id    <= '0;
         o_Rsp_Data  <= '0;
         ptr_q       <= '0;
         last_sel_q  <= REG_ZERO;
      end else if (grant_any_c) begin
         o_Rsp_Valid <= 1'b1;
         o_Rsp_Id    <= winner_c;
         o_Rsp_Data  <= cap_data_c;
         ptr_q       <= ptr_next_c;
         last_sel_q  <= win_addr_c;
      end else if ((state_q == RESP) && in_Rsp_Ready) begin
         o_Rsp_Valid <= 1'b0;
      end
   end

endmodule : regfile_read_arbiter

// File: tb/tb_regfile_read_arbiter.sv
// Self-checking bench for regfile_read_arbiter: directed scenarios plus a randomized run against a queue-free cycle model.
module tb_regfile_read_arbiter;

   localparam int NUM_REQ = 4;
`ifdef REGFILE_ARB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  in_Req_Valid;
   logic [19:0] in_Req_Addr;
   logic [3:0]  o_Req_Ready;
   logic [4:0]  o_MUX_Selector_5;
   logic [31:0] in_MUX_Data;
   logic        in_Wr_En;
   logic [4:0]  in_Wr_Addr;
   logic [31:0] in_Wr_Data;
   logic        o_Rsp_Valid;
   logic [1:0]  o_Rsp_Id;
   logic [31:0] o_Rsp_Data;
   logic        in_Rsp_Ready;

   int checks = 0;
   int passes = 0;

   // Reference model state
   bit          m_busy;
   int          m_id, m_ptr;
   logic [31:0] m_data;
   logic [4:0]  m_last;
   bit          e_grant;
   int          e_win;
   logic [3:0]  e_ready;
   logic [4:0]  e_sel;
   logic [31:0] e_cap;

   always #5 clk = ~clk;

   regfile_read_arbiter #(.N(32), .NUM_REQ(4), .ID_W(2)) dut (
      .clk              (clk),
      .reset            (reset),
      .in_Req_Valid     (in_Req_Valid),
      .in_Req_Addr      (in_Req_Addr),
      .o_Req_Ready      (o_Req_Ready),
      .o_MUX_Selector_5 (o_MUX_Selector_5),
      .in_MUX_Data      (in_MUX_Data),
      .in_Wr_En         (in_Wr_En),
      .in_Wr_Addr       (in_Wr_Addr),
      .in_Wr_Data       (in_Wr_Data),
      .o_Rsp_Valid      (o_Rsp_Valid),
      .o_Rsp_Id         (o_Rsp_Id),
      .o_Rsp_Data       (o_Rsp_Data),
      .in_Rsp_Ready     (in_Rsp_Ready)
   );

   task automatic set_addrs(input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] a3);
      in_Req_Addr = {a3, a2, a1, a0};
   endtask

   task automatic do_reset();
      reset        = 1'b0;
      in_Req_Valid = 4'b0000;
      in_Req_Addr  = '0;
      in_MUX_Data  = '0;
      in_Wr_En     = 1'b0;
      in_Wr_Addr   = '0;
      in_Wr_Data   = '0;
      in_Rsp_Ready = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   // Next grant from the spec rules: first valid requester at/after the pointer when the slot is free.
   task automatic model_eval();
      logic [4:0] a;
      int i;
      e_grant = 1'b0;
      e_win   = 0;
      e_ready = 4'b0000;
      e_sel   = m_last;
      e_cap   = '0;
      if (reset && (!m_busy || in_Rsp_Ready)) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            i = (m_ptr + k) % NUM_REQ;
            if (!e_grant && in_Req_Valid[i]) begin
               e_grant = 1'b1;
               e_win   = i;
            end
         end
      end
      if (e_grant) begin
         e_ready[e_win] = 1'b1;
         a     = in_Req_Addr[e_win*5 +: 5];
         e_sel = a;
         if (a == 5'd0) e_cap = '0;
         else if (BYP && in_Wr_En && (in_Wr_Addr == a)) e_cap = in_Wr_Data;
         else e_cap = in_MUX_Data;
      end
   endtask

   task automatic model_commit();
      if (e_grant) begin
         m_busy = 1'b1;
         m_id   = e_win;
         m_data = e_cap;
         m_ptr  = (e_win + 1) % NUM_REQ;
         m_last = e_sel;
      end else if (m_busy && in_Rsp_Ready) begin
         m_busy = 1'b0;
      end
   endtask

   task automatic test_reset();
      reset        = 1'b0;
      in_Req_Valid = 4'b1111;
      set_addrs(5'd3, 5'd8, 5'd17, 5'd30);
      in_MUX_Data  = 32'h0000_0055;
      in_Wr_En     = 1'b0;
      in_Wr_Addr   = '0;
      in_Wr_Data   = '0;
      in_Rsp_Ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (o_Req_Ready !== 4'b0000) $display("FAIL rst_ready got %b exp 0000", o_Req_Ready); else passes++;
      checks++; if (o_MUX_Selector_5 !== 5'd0) $display("FAIL rst_sel got %0d exp 0", o_MUX_Selector_5); else passes++;
      checks++; if (o_Rsp_Valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", o_Rsp_Valid); else passes++;
      checks++; if (o_Rsp_Id !== 2'd0) $display("FAIL rst_id got %0d exp 0", o_Rsp_Id); else passes++;
      checks++; if (o_Rsp_Data !== 32'd0) $display("FAIL rst_data got %h exp 0", o_Rsp_Data); else passes++;
      reset = 1'b1;
      #1;
      checks++; if (o_Req_Ready !== 4'b0001) $display("FAIL rel_ready got %b exp 0001", o_Req_Ready); else passes++;
      checks++; if (o_MUX_Selector_5 !== 5'd3) $display("FAIL rel_sel got %0d exp 3", o_MUX_Selector_5); else passes++;
      @(posedge clk);
      #1;
      checks++; if (o_Rsp_Valid !== 1'b1) $display("FAIL rel_rsp_valid got %b exp 1", o_Rsp_Valid); else passes++;
      checks++; if (o_Rsp_Data !== 32'h55) $display("FAIL rel_rsp_data got %h exp 00000055", o_Rsp_Data); else passes++;
   endtask

   task automatic test_round_robin();
      logic [31:0] d;
      int g;
      do_reset();
      in_Req_Valid = 4'b1111;
      set_addrs(5'd3, 5'd8, 5'd17, 5'd30);
      for (int k = 0; k < 5; k++) begin
         g = k % NUM_REQ;
         d = $urandom;
         in_MUX_Data = d;
         #1;
         checks++; if (o_Req_Ready !== 4'(1 << g)) $display("FAIL rr_ready[%0d] got %b exp %b", k, o_Req_Ready, 4'(1 << g)); else passes++;
         @(posedge clk);
         #1;
         checks++; if (o_Rsp_Valid !== 1'b1 || o_Rsp_Id !== 2'(g)) $display("FAIL rr_rsp[%0d] got v%b id%0d exp v1 id%0d", k, o_Rsp_Valid, o_Rsp_Id, g); else passes++;
         checks++; if (o_Rsp_Data !== d) $display("FAIL rr_data[%0d] got %h exp %h", k, o_Rsp_Data, d); else passes++;
      end
   endtask

   task automatic test_basic_read();
      do_reset();
      in_Req_Valid = 4'b0010;
      set_addrs(5'd1, 5'd8, 5'd2, 5'd3);
      in_MUX_Data = 32'hDEAD_BEEF;
      #1;
      checks++; if (o_Req_Ready !== 4'b0010) $display("FAIL rd_ready got %b exp 0010", o_Req_Ready); else passes++;
      checks++; if (o_MUX_Selector_5 !== 5'd8) $display("FAIL rd_sel got %0d exp 8", o_MUX_Selector_5); else passes++;
      @(posedge clk);
      #1;
      in_Req_Valid = 4'b0000;
      checks++; if (o_Rsp_Valid !== 1'b1 || o_Rsp_Id !== 2'd1) $display("FAIL rd_rsp got v%b id%0d exp v1 id1", o_Rsp_Valid, o_Rsp_Id); else passes++;
      checks++; if (o_Rsp_Data !== 32'hDEAD_BEEF) $display("FAIL rd_data got %h exp deadbeef", o_Rsp_Data); else passes++;
      @(posedge clk);
      #1;
      checks++; if (o_Rsp_Valid !== 1'b0) $display("FAIL rd_drain got %b exp 0", o_Rsp_Valid); else passes++;
   endtask

   task automatic test_backpressure();
      do_reset();
      set_addrs(5'd4, 5'd8, 5'd17, 5'd22);
      in_Req_Valid = 4'b0010;
      in_MUX_Data  = 32'h0000_00A1;
      @(posedge clk);
      #1;
      in_Req_Valid = 4'b0110;
      in_Rsp_Ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         in_MUX_Data = $urandom;
         #1;
         checks++; if (o_Req_Ready !== 4'b0000) $display("FAIL bp_ready[%0d] got %b exp 0000", k, o_Req_Ready); else passes++;
         checks++; if (o_MUX_Selector_5 !== 5'd8) $display("FAIL bp_sel[%0d] got %0d exp 8", k, o_MUX_Selector_5); else passes++;
         checks++; if (o_Rsp_Valid !== 1'b1 || o_Rsp_Id !== 2'd1 || o_Rsp_Data !== 32'hA1) $display("FAIL bp_hold[%0d] got v%b id%0d %h exp v1 id1 000000a1", k, o_Rsp_Valid, o_Rsp_Id, o_Rsp_Data); else passes++;
         @(posedge clk);
         #1;
      end
      in_Rsp_Ready = 1'b1;
      in_MUX_Data  = 32'h0000_00B2;
      #1;
      checks++; if (o_Req_Ready !== 4'b0100) $display("FAIL bp_release got %b exp 0100", o_Req_Ready); else passes++;
      checks++; if (o_MUX_Selector_5 !== 5'd17) $display("FAIL bp_rel_sel got %0d exp 17", o_MUX_Selector_5); else passes++;
      @(posedge clk);
      #1;
      checks++; if (o_Rsp_Valid !== 1'b1 || o_Rsp_Id !== 2'd2 || o_Rsp_Data !== 32'hB2) $display("FAIL bp_next got v%b id%0d %h exp v1 id2 000000b2", o_Rsp_Valid, o_Rsp_Id, o_Rsp_Data); else passes++;
   endtask

   task automatic test_addr_zero();
      do_reset();
      in_Req_Valid = 4'b0001;
      set_addrs(5'd0, 5'd5, 5'd6, 5'd7);
      in_MUX_Data = 32'h0000_1234;
      in_Wr_En    = 1'b1;
      in_Wr_Addr  = 5'd0;
      in_Wr_Data  = 32'h0000_7777;
      @(posedge clk);
      #1;
      checks++; if (o_Rsp_Valid !== 1'b1 || o_Rsp_Data !== 32'd0) $display("FAIL zero_data got v%b %h exp v1 00000000", o_Rsp_Valid, o_Rsp_Data); else passes++;
   endtask

   task automatic test_bypass_and_reset();
      logic [31:0] exp_d;
      exp_d = BYP ? 32'h0000_CAFE : 32'h0000_0001;
      do_reset();
      in_Req_Valid = 4'b0001;
      set_addrs(5'd9, 5'd1, 5'd2, 5'd3);
      in_Wr_En    = 1'b1;
      in_Wr_Addr  = 5'd9;
      in_Wr_Data  = 32'h0000_CAFE;
      in_MUX_Data = 32'h0000_0001;
      @(posedge clk);
      #1;
      checks++; if (o_Rsp_Data !== exp_d) $display("FAIL fwd_data got %h exp %h", o_Rsp_Data, exp_d); else passes++;
      in_Req_Valid = 4'b0000;
      in_Wr_En     = 1'b0;
      in_Rsp_Ready = 1'b0;
      @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      checks++; if (o_Rsp_Valid !== 1'b0 || o_Rsp_Data !== 32'd0) $display("FAIL midrst got v%b %h exp v0 00000000", o_Rsp_Valid, o_Rsp_Data); else passes++;
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   task automatic test_random();
      int r;
      do_reset();
      m_busy = 1'b0; m_id = 0; m_ptr = 0; m_data = '0; m_last = '0;
      for (int c = 0; c < 400; c++) begin
         checks++; if (o_Rsp_Valid !== m_busy) $display("FAIL rnd_valid[%0d] got %b exp %b", c, o_Rsp_Valid, m_busy); else passes++;
         if (m_busy) begin
            checks++; if (o_Rsp_Id !== 2'(m_id) || o_Rsp_Data !== m_data) $display("FAIL rnd_rsp[%0d] got id%0d %h exp id%0d %h", c, o_Rsp_Id, o_Rsp_Data, m_id, m_data); else passes++;
         end
         in_Req_Valid = 4'($urandom_range(0, 15));
         for (int i = 0; i < NUM_REQ; i++) begin
            in_Req_Addr[i*5 +: 5] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         end
         in_Rsp_Ready = ($urandom_range(0, 3) != 0);
         in_Wr_En     = $urandom_range(0, 1) == 1;
         r            = $urandom_range(0, NUM_REQ - 1);
         in_Wr_Addr   = ($urandom_range(0, 1) == 1) ? in_Req_Addr[r*5 +: 5] : 5'($urandom_range(0, 31));
         in_Wr_Data   = $urandom;
         in_MUX_Data  = $urandom;
         model_eval();
         #1;
         checks++; if (o_Req_Ready !== e_ready) $display("FAIL rnd_ready[%0d] got %b exp %b", c, o_Req_Ready, e_ready); else passes++;
         checks++; if (o_MUX_Selector_5 !== e_sel) $display("FAIL rnd_sel[%0d] got %0d exp %0d", c, o_MUX_Selector_5, e_sel); else passes++;
         @(posedge clk);
         model_commit();
         #1;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_round_robin();
      test_basic_read();
      test_backpressure();
      test_addr_zero();
      test_bypass_and_reset();
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule : tb_regfile_read_arbiter
